// File: rtl/vga_timing_gen.sv
// VGA 640x480 pixel-coordinate and sync generator with an internal pixel clock-enable.
// Optional macro VGA_PIPE_EN delays sync/blank/frame pulses by one pixel for a one-pixel-latency colour path.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start,
  output logic       frame_clk
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_cfg_check
    $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hc_q, hc_d, vc_q, vc_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic             fs_q, fs_d, fc_q, fc_d;

  assign pixel_ce   = (div_q == DIV_LAST);
  assign DrawX      = hc_q;
  assign DrawY      = vc_q;
  assign VGA_SYNC_N = 1'b0;

  // Sync, blank and frame pulses are decoded from the next counter values so they land with DrawX/DrawY.
  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (pixel_ce) begin
      div_d = DIV_ZERO;
      if (hc_q == H_LAST) begin
        hc_d = 10'd0;
        if (vc_q == V_LAST) begin
          vc_d = 10'd0;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
      end
    end else begin
      div_d = div_q + DIV_ONE;
    end
    hs_d    = ~((hc_d >= HS_BEG) && (hc_d <= HS_END));
    vs_d    = ~((vc_d >= VS_BEG) && (vc_d <= VS_END));
    blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
    fs_d    = pixel_ce && (hc_d == 10'd0) && (vc_d == 10'd0);
    fc_d    = pixel_ce && (hc_d == 10'd0) && (vc_d == V_VIS);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q   <= DIV_ZERO;
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

`ifdef VGA_PIPE_EN
  logic hs_p_q, hs_p_d, vs_p_q, vs_p_d, blank_p_q, blank_p_d;
  logic fs_p_q, fs_p_d, fc_p_q, fc_p_d;
  logic fs_pend_q, fs_pend_d, fc_pend_q, fc_pend_d;

  // A pulse seen mid-pixel is held pending, then re-emitted for one Clk at the next pixel boundary.
  always_comb begin
    hs_p_d    = hs_p_q;
    vs_p_d    = vs_p_q;
    blank_p_d = blank_p_q;
    fs_pend_d = fs_pend_q;
    fc_pend_d = fc_pend_q;
    if (pixel_ce) begin
      hs_p_d    = hs_q;
      vs_p_d    = vs_q;
      blank_p_d = blank_q;
      fs_pend_d = 1'b0;
      fc_pend_d = 1'b0;
    end else begin
      fs_pend_d = fs_pend_q | fs_q;
      fc_pend_d = fc_pend_q | fc_q;
    end
    fs_p_d = pixel_ce & (fs_pend_q | fs_q);
    fc_p_d = pixel_ce & (fc_pend_q | fc_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_p_q    <= 1'b1;
      vs_p_q    <= 1'b1;
      blank_p_q <= 1'b1;
      fs_p_q    <= 1'b0;
      fc_p_q    <= 1'b0;
      fs_pend_q <= 1'b0;
      fc_pend_q <= 1'b0;
    end else begin
      hs_p_q    <= hs_p_d;
      vs_p_q    <= vs_p_d;
      blank_p_q <= blank_p_d;
      fs_p_q    <= fs_p_d;
      fc_p_q    <= fc_p_d;
      fs_pend_q <= fs_pend_d;
      fc_pend_q <= fc_pend_d;
    end
  end

  assign VGA_HS      = hs_p_q;
  assign VGA_VS      = vs_p_q;
  assign VGA_BLANK_N = blank_p_q;
  assign frame_start = fs_p_q;
  assign frame_clk   = fc_p_q;
`else
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign frame_start = fs_q;
  assign frame_clk   = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen; expected outputs come from an arithmetic model of
// elapsed Clk edges (pixel index = edges / CLK_DIV). Vertical timing is shortened to keep runs small.
module tb_vga_timing_gen;

  localparam int CLK_DIV   = 2;
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 6;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 1;
  localparam int HT        = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT        = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CYC = HT * VT * CLK_DIV;
`ifdef VGA_PIPE_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       pixel_ce, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start, frame_clk;
  logic [9:0] DrawX, DrawY;

  int checks = 0;
  int failures = 0;
  int n_edges = 0;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce), .DrawX(DrawX), .DrawY(DrawY),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .frame_start(frame_start), .frame_clk(frame_clk)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Returns {x[9:0], y[9:0], hs, vs, blank_n, ce, frame_start, frame_clk} after n edges out of reset.
  function automatic logic [25:0] model(input int n);
    int p, ph, q, qx, qy;
    logic hs, vs, bl, ce, fs, fc;
    logic [9:0] ex, ey;
    p  = n / CLK_DIV;
    ph = n % CLK_DIV;
    ce = (ph == CLK_DIV - 1);
    ex = 10'(p % HT);
    ey = 10'((p / HT) % VT);
    q  = p - LAG;
    hs = 1'b1; vs = 1'b1; bl = 1'b1; fs = 1'b0; fc = 1'b0;
    if (q >= 0) begin
      qx = q % HT;
      qy = (q / HT) % VT;
      hs = !(qx >= H_VISIBLE + H_FP && qx < H_VISIBLE + H_FP + H_SYNC);
      vs = !(qy >= V_VISIBLE + V_FP && qy < V_VISIBLE + V_FP + V_SYNC);
      bl = (qx < H_VISIBLE) && (qy < V_VISIBLE);
      fs = (ph == 0) && (q > 0) && (qx == 0) && (qy == 0);
      fc = (ph == 0) && (qx == 0) && (qy == V_VISIBLE);
    end
    return {ex, ey, hs, vs, bl, ce, fs, fc};
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  // Per-cycle model comparison plus run-length / position measurements on the falling edge.
  initial begin
    logic [25:0] e;
    int hs_run, vs_run, cyc, last_fs;
    bit have_fs, prev_hs;
    hs_run = 0; vs_run = 0; cyc = 0; last_fs = 0; have_fs = 1'b0; prev_hs = 1'b1;
    forever begin
      @(negedge Clk);
      cyc++;
      e = model(n_edges);
      check_eq("draw_xy", 32'({DrawX, DrawY}), 32'(e[25:6]));
      check_eq("sync_blank", 32'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N}), 32'({e[5:3], 1'b0}));
      check_eq("ce_pulses", 32'({pixel_ce, frame_start, frame_clk}), 32'(e[2:0]));
      if (Reset) begin
        hs_run = 0; vs_run = 0; have_fs = 1'b0; prev_hs = 1'b1;
      end else begin
        if (prev_hs && !VGA_HS) check_eq("hs_fall_x", 32'(DrawX), 32'(H_VISIBLE + H_FP + LAG));
        prev_hs = VGA_HS;
        if (!VGA_HS) hs_run++;
        else if (hs_run != 0) begin
          check_eq("hs_low_len", 32'(hs_run), 32'(H_SYNC * CLK_DIV));
          hs_run = 0;
        end
        if (!VGA_VS) vs_run++;
        else if (vs_run != 0) begin
          check_eq("vs_low_len", 32'(vs_run), 32'(V_SYNC * HT * CLK_DIV));
          vs_run = 0;
        end
        if (frame_start) begin
          check_eq("fs_pos", 32'({DrawX, DrawY}), 32'(LAG << 10));
          if (have_fs) check_eq("fs_period", 32'(cyc - last_fs), 32'(FRAME_CYC));
          have_fs = 1'b1;
          last_fs = cyc;
        end
        if (frame_clk)
          check_eq("fc_pos", 32'({DrawX, DrawY, VGA_BLANK_N}), 32'((LAG << 11) | (V_VISIBLE << 1)));
      end
    end
  end

  task automatic async_reset(input int hold);
    #2 Reset = 1'b1;
    #1 check_eq("async_rst",
                32'({DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, frame_clk, pixel_ce}),
                32'({20'd0, 6'b111000}));
    repeat (hold) @(posedge Clk);
    #2 Reset = 1'b0;
  endtask

  initial begin
    #1 Reset = 1'b1;
    repeat (5) @(posedge Clk);
    #2 Reset = 1'b0;
    repeat (2 * FRAME_CYC + 300) @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      async_reset(int'($urandom_range(4, 1)));
      repeat ($urandom_range(2500, 100)) @(posedge Clk);
    end
    // Abort a frame after its frame_clk but before frame_start, then let a full frame elapse.
    @(posedge Clk);
    async_reset(3);
    repeat (FRAME_CYC - 4000) @(posedge Clk);
    async_reset(int'($urandom_range(5, 1)));
    repeat (FRAME_CYC + 500) @(posedge Clk);
    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
